// File: rtl/morse_defs_pkg.sv
// Shared definitions for the Morse receive path: FSM states, timing
// multipliers in Morse units, and the ASCII bytes the receiver emits itself.
package morse_defs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int MAX_SYMBOLS_DEFAULT = 6;

  // Mark/space thresholds in units: dash and inter-character gap share 2,
  // a word gap is 5, and the duration counter saturates at 8.
  localparam int CHAR_GAP_UNITS = 2;
  localparam int WORD_GAP_UNITS = 5;
  localparam int SAT_UNITS      = 8;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse code table: {length, symbols} -> ASCII.
// Dash = 1, dot = 0; the first symbol sent sits in the top used bit.
module morse_lut
  import morse_defs_pkg::*;
(
  input  logic [2:0] len,
  input  logic [5:0] pattern,
  output logic [7:0] ascii,
  output logic       hit
);

  logic [5:0] used;

  // Clear bits above the symbol count so stale history never aliases a shorter code.
  assign used = pattern & 6'((7'd1 << len) - 7'd1);

  // Table lookup keyed on length and the used symbol bits.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    ascii = ASCII_UNKNOWN;
    hit   = 1'b1;
    case ({len, used})
      {3'd1, 6'b000000}: ascii = "E";
      {3'd1, 6'b000001}: ascii = "T";
      {3'd2, 6'b000000}: ascii = "I";
      {3'd2, 6'b000001}: ascii = "A";
      {3'd2, 6'b000010}: ascii = "N";
      {3'd2, 6'b000011}: ascii = "M";
      {3'd3, 6'b000000}: ascii = "S";
      {3'd3, 6'b000001}: ascii = "U";
      {3'd3, 6'b000010}: ascii = "R";
      {3'd3, 6'b000011}: ascii = "W";
      {3'd3, 6'b000100}: ascii = "D";
      {3'd3, 6'b000101}: ascii = "K";
      {3'd3, 6'b000110}: ascii = "G";
      {3'd3, 6'b000111}: ascii = "O";
      {3'd4, 6'b000000}: ascii = "H";
      {3'd4, 6'b000001}: ascii = "V";
      {3'd4, 6'b000010}: ascii = "F";
      {3'd4, 6'b000100}: ascii = "L";
      {3'd4, 6'b000110}: ascii = "P";
      {3'd4, 6'b000111}: ascii = "J";
      {3'd4, 6'b001000}: ascii = "B";
      {3'd4, 6'b001001}: ascii = "X";
      {3'd4, 6'b001010}: ascii = "C";
      {3'd4, 6'b001011}: ascii = "Y";
      {3'd4, 6'b001100}: ascii = "Z";
      {3'd4, 6'b001101}: ascii = "Q";
      {3'd5, 6'b011111}: ascii = "0";
      {3'd5, 6'b001111}: ascii = "1";
      {3'd5, 6'b000111}: ascii = "2";
      {3'd5, 6'b000011}: ascii = "3";
      {3'd5, 6'b000001}: ascii = "4";
      {3'd5, 6'b000000}: ascii = "5";
      {3'd5, 6'b010000}: ascii = "6";
      {3'd5, 6'b011000}: ascii = "7";
      {3'd5, 6'b011100}: ascii = "8";
      {3'd5, 6'b011110}: ascii = "9";
      {3'd5, 6'b010010}: ascii = "/";
      {3'd6, 6'b010101}: ascii = ".";
      {3'd6, 6'b110011}: ascii = ",";
      {3'd6, 6'b001100}: ascii = "?";
      default:           hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_receiver.sv
// Morse receiver: synchronizes the keyed light signal, times marks and
// spaces in unit ticks, classifies dots/dashes and emits one ASCII byte per
// character plus a single space byte per word gap.
module morse_receiver
  import morse_defs_pkg::*;
#(
  parameter int UNIT_TICKS  = 160,
  parameter int MAX_SYMBOLS = MAX_SYMBOLS_DEFAULT
) (
  input  logic       UnitClock,
  input  logic       Reset,
  input  logic       ONOFF,
  output logic [7:0] Char,
  output logic       CharValid,
  output logic       CharError,
  output logic       isDash,
  output logic       SymbolValid
);

  localparam int CW = $clog2(SAT_UNITS * UNIT_TICKS) + 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(SAT_UNITS * UNIT_TICKS);
  localparam logic [CW-1:0] DASH_MIN  = CW'(CHAR_GAP_UNITS * UNIT_TICKS);
  // Emission happens on the cycle whose increment would reach the threshold.
  localparam logic [CW-1:0] CHAR_LAST = CW'(CHAR_GAP_UNITS * UNIT_TICKS - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(WORD_GAP_UNITS * UNIT_TICKS - 1);
  localparam logic [2:0]    LEN_MAX   = 3'(MAX_SYMBOLS);

  logic          sync_meta, sync_on;
  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt, count_inc;
  logic [2:0]    sym_len, sym_len_nxt;
  logic [5:0]    pattern, pattern_nxt;
  logic          overflow, overflow_nxt;
  logic [7:0]    char_nxt;
  logic          char_valid_nxt, char_error_nxt, is_dash_nxt, symbol_valid_nxt;
  logic          mark_is_dash;
  logic [7:0]    lut_ascii;
  logic          lut_hit;

  morse_lut u_lut (
    .len     (sym_len),
    .pattern (pattern),
    .ascii   (lut_ascii),
    .hit     (lut_hit)
  );

  assign count_inc    = (count == CNT_SAT) ? count : count + CNT_ONE;
  assign mark_is_dash = (count >= DASH_MIN);

  // Two-flop synchronizer for the asynchronous keying input.
  always_ff @(posedge UnitClock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      sync_meta <= 1'b0;
      sync_on   <= 1'b0;
    end else begin
      sync_meta <= ONOFF;
      sync_on   <= sync_meta;
    end
  end

  // State, duration counter, symbol accumulator and registered outputs.
  always_ff @(posedge UnitClock) begin
    if (Reset) begin
      state       <= IDLE;
      count       <= '0;
      sym_len     <= '0;
      pattern     <= '0;
      overflow    <= 1'b0;
      Char        <= 8'h00;
      CharValid   <= 1'b0;
      CharError   <= 1'b0;
      isDash      <= 1'b0;
      SymbolValid <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      sym_len     <= sym_len_nxt;
      pattern     <= pattern_nxt;
      overflow    <= overflow_nxt;
      Char        <= char_nxt;
      CharValid   <= char_valid_nxt;
      CharError   <= char_error_nxt;
      isDash      <= is_dash_nxt;
      SymbolValid <= symbol_valid_nxt;
    end
  end

  // Next-state logic: time marks/spaces, classify symbols, emit characters.
  always_comb begin
    state_nxt        = state;
    count_nxt        = count;
    sym_len_nxt      = sym_len;
    pattern_nxt      = pattern;
    overflow_nxt     = overflow;
    char_nxt         = Char;
    char_valid_nxt   = 1'b0;
    char_error_nxt   = 1'b0;
    is_dash_nxt      = isDash;
    symbol_valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (sync_on) begin
          state_nxt = MARK;
          count_nxt = CNT_ONE;
        end
      end

      MARK: begin
        if (sync_on) begin
          count_nxt = count_inc;
        end else begin
          is_dash_nxt      = mark_is_dash;
          symbol_valid_nxt = 1'b1;
          pattern_nxt      = {pattern[4:0], mark_is_dash};
          // Too many symbols: remember it, but keep the length in LUT range.
          if (sym_len == LEN_MAX) overflow_nxt = 1'b1;
          else                    sym_len_nxt  = sym_len + 3'd1;
          state_nxt = SPACE;
          count_nxt = CNT_ONE;
        end
      end

      SPACE: begin
        if (sync_on) begin
          state_nxt = MARK;
          count_nxt = CNT_ONE;
        end else begin
          count_nxt = count_inc;
          if (count == CHAR_LAST) begin
            char_valid_nxt = 1'b1;
            if (overflow || !lut_hit) begin
              char_nxt       = ASCII_UNKNOWN;
              char_error_nxt = 1'b1;
            end else begin
              char_nxt = lut_ascii;
            end
            sym_len_nxt  = '0;
            pattern_nxt  = '0;
            overflow_nxt = 1'b0;
            state_nxt    = GAP;
          end
        end
      end

      GAP: begin
        if (sync_on) begin
          state_nxt = MARK;
          count_nxt = CNT_ONE;
        end else if (count == WORD_LAST) begin
          char_nxt       = ASCII_SPACE;
          char_valid_nxt = 1'b1;
          state_nxt      = IDLE;
          count_nxt      = '0;
        end else begin
          count_nxt = count_inc;
        end
      end

      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

endmodule
